// File: rtl/fconv_float_encoder.sv
// Two-stage pipeline converting a 12-bit two's-complement sample into an 8-bit
// sign/exponent/significand code. Optional rounding is enabled by FCONV_ROUND_EN.
module fconv_float_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [11:0] D,
    output logic        out_valid,
    output logic        S,
    output logic [2:0]  E,
    output logic [3:0]  F
);

    // Leading zeros of a 12-bit magnitude (12 when the value is zero).
    function automatic logic [3:0] count_lz(input logic [11:0] m);
        logic [3:0] n;
        logic       done;
        n    = 4'd0;
        done = 1'b0;
        for (int i = 11; i >= 0; i--) begin
            if (done) begin
                n = n;
            end else if (m[i]) begin
                done = 1'b1;
            end else begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    logic [11:0] mag_s;
    logic        s1_valid_r;
    logic        s1_sign_r;
    logic [11:0] s1_mag_r;
    logic [3:0]  s1_lz_r;
    logic [2:0]  e_raw_s;
    logic [3:0]  f_raw_s;
    logic [2:0]  e_fin_s;
    logic [3:0]  f_fin_s;

    // Magnitude of the input; -2048 has no positive twin so it saturates.
    always_comb begin
        mag_s = D;
        if (D == 12'h800) begin
            mag_s = 12'h7FF;
        end else if (D[11]) begin
            mag_s = ~D + 12'd1;
        end else begin
            mag_s = D;
        end
    end

    // Stage 1: sign, magnitude and leading-zero count; data held when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_mag_r   <= 12'd0;
            s1_lz_r    <= 4'd0;
        end else begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_sign_r <= D[11];
                s1_mag_r  <= mag_s;
                s1_lz_r   <= count_lz(mag_s);
            end else begin
                s1_sign_r <= s1_sign_r;
                s1_mag_r  <= s1_mag_r;
                s1_lz_r   <= s1_lz_r;
            end
        end
    end

    // Exponent from the leading-zero count, then the 4-bit window above it.
    always_comb begin
        e_raw_s = 3'd0;
        if ((s1_lz_r >= 4'd1) && (s1_lz_r <= 4'd7)) begin
            e_raw_s = 3'(4'd8 - s1_lz_r);
        end else begin
            e_raw_s = 3'd0;
        end
        f_raw_s = 4'(s1_mag_r >> e_raw_s);
    end

`ifdef FCONV_ROUND_EN
    logic round_bit_s;

    // Round half up; a significand carry renormalises to 8 and bumps E,
    // and the largest code saturates instead of wrapping.
    always_comb begin
        e_fin_s     = e_raw_s;
        f_fin_s     = f_raw_s;
        round_bit_s = 1'b0;
        if (e_raw_s != 3'd0) begin
            round_bit_s = s1_mag_r[e_raw_s - 3'd1];
        end else begin
            round_bit_s = 1'b0;
        end
        if (!round_bit_s) begin
            e_fin_s = e_raw_s;
            f_fin_s = f_raw_s;
        end else if (f_raw_s != 4'd15) begin
            f_fin_s = f_raw_s + 4'd1;
        end else if (e_raw_s == 3'd7) begin
            e_fin_s = 3'd7;
            f_fin_s = 4'd15;
        end else begin
            e_fin_s = e_raw_s + 3'd1;
            f_fin_s = 4'd8;
        end
    end
`else
    // Truncation: the window is used as is.
    always_comb begin
        e_fin_s = e_raw_s;
        f_fin_s = f_raw_s;
    end
`endif

    // Stage 2: output register; S/E/F keep the last result while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            S         <= 1'b0;
            E         <= 3'd0;
            F         <= 4'd0;
        end else begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                S <= s1_sign_r & (s1_mag_r != 12'd0);
                E <= e_fin_s;
                F <= f_fin_s;
            end else begin
                S <= S;
                E <= E;
                F <= F;
            end
        end
    end

endmodule

// File: tb/tb_fconv_float_encoder.sv
// Directed self-checking bench for fconv_float_encoder; expected codes follow
// the FCONV_ROUND_EN setting used for the build.
module tb_fconv_float_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] d;
    logic        out_valid;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;

    int n_checks;
    int n_errors;

    logic [11:0] vec_d [6];
    logic        vec_s [6];
    logic [2:0]  vec_e [6];
    logic [3:0]  vec_f [6];

    fconv_float_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .D        (d),
        .out_valid(out_valid),
        .S        (s),
        .E        (e),
        .F        (f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_code(input string tag, input int idx);
        check_val({tag, "_valid"}, {11'd0, out_valid}, 12'd1);
        check_val({tag, "_S"}, {11'd0, s}, {11'd0, vec_s[idx]});
        check_val({tag, "_E"}, {9'd0, e}, {9'd0, vec_e[idx]});
        check_val({tag, "_F"}, {8'd0, f}, {8'd0, vec_f[idx]});
    endtask

    // Send one sample alone and check its 2-clock latency and the hold afterwards.
    task automatic run_single(input int idx);
        @(negedge clk);
        d        = vec_d[idx];
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        d        = 12'h5A5;
        check_val($sformatf("single%0d_lat1", idx), {11'd0, out_valid}, 12'd0);
        @(negedge clk);
        check_code($sformatf("single%0d", idx), idx);
        @(negedge clk);
        check_val($sformatf("single%0d_drop", idx), {11'd0, out_valid}, 12'd0);
        check_val($sformatf("single%0d_holdE", idx), {9'd0, e}, {9'd0, vec_e[idx]});
        check_val($sformatf("single%0d_holdF", idx), {8'd0, f}, {8'd0, vec_f[idx]});
    endtask

    initial begin
        int          str_idx [8];
        logic        str_vld [8];

        n_checks = 0;
        n_errors = 0;

        vec_d[0] = 12'd125;  vec_s[0] = 1'b0;
`ifdef FCONV_ROUND_EN
        vec_e[0] = 3'd4;     vec_f[0] = 4'd8;
`else
        vec_e[0] = 3'd3;     vec_f[0] = 4'd15;
`endif
        vec_d[1] = 12'd2047; vec_s[1] = 1'b0; vec_e[1] = 3'd7; vec_f[1] = 4'd15;
        vec_d[2] = 12'd422;  vec_s[2] = 1'b0; vec_e[2] = 3'd5; vec_f[2] = 4'd13;
        vec_d[3] = 12'hFFF;  vec_s[3] = 1'b1; vec_e[3] = 3'd0; vec_f[3] = 4'd1;
        vec_d[4] = 12'h000;  vec_s[4] = 1'b0; vec_e[4] = 3'd0; vec_f[4] = 4'd0;
        vec_d[5] = 12'h800;  vec_s[5] = 1'b1; vec_e[5] = 3'd7; vec_f[5] = 4'd15;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        d        = 12'd0;
        repeat (2) @(negedge clk);
        check_val("rst_valid", {11'd0, out_valid}, 12'd0);
        check_val("rst_E", {9'd0, e}, 12'd0);
        check_val("rst_F", {8'd0, f}, 12'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_single(i);
        end

        // Back-to-back stream of the first five vectors with one bubble.
        str_idx = '{0, 1, 0, 2, 3, 4, 0, 0};
        str_vld = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 2) begin
                if (str_vld[k-2]) begin
                    check_code($sformatf("stream%0d", k - 2), str_idx[k-2]);
                end else begin
                    check_val($sformatf("stream%0d_bubble", k - 2), {11'd0, out_valid}, 12'd0);
                end
            end
            if (k < 8) begin
                in_valid = str_vld[k];
                d        = str_vld[k] ? vec_d[str_idx[k]] : 12'h3C3;
            end else begin
                in_valid = 1'b0;
            end
        end

        // Asynchronous reset mid-stream with valid data in flight.
        @(negedge clk);
        in_valid = 1'b1;
        d        = vec_d[1];
        repeat (2) @(negedge clk);
        check_code("pre_rst", 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", {11'd0, out_valid}, 12'd0);
        check_val("async_rst_S", {11'd0, s}, 12'd0);
        check_val("async_rst_E", {9'd0, e}, 12'd0);
        check_val("async_rst_F", {8'd0, f}, 12'd0);
        @(negedge clk);
        d     = vec_d[2];
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("post_rst_lat1", {11'd0, out_valid}, 12'd0);
        @(negedge clk);
        check_code("post_rst", 2);
        @(negedge clk);
        check_val("post_rst_drop", {11'd0, out_valid}, 12'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
